// File: rtl/mult_bcd_conv.sv
// Shift-add-3 binary-to-BCD converter for the multiplier product, start/busy/done handshake.
// Latency WIDTH+1 from accepted start to done; start while busy or in DONE is dropped.
module mult_bcd_conv #(
  parameter int WIDTH      = 8,
  parameter bit AUTO_START = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  localparam int SW = 12 + WIDTH;
  localparam logic [3:0] LAST_IT = 4'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [11:0]      dig_q, dig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SW-1:0]    adj;
  logic [3:0]       nib;
  logic             trig;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    cap_d   = cap_q;
    last_d  = last_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    // busy trails the SHIFT state by one cycle so it spans exactly the WIDTH iterations
    busy_d  = (state_q == S_SHIFT);
    trig    = start || (AUTO_START && (bin != last_q));

    adj = sreg_q;
    nib = 4'd0;
    for (int i = 0; i < 3; i++) begin
      nib = sreg_q[WIDTH + 4*i +: 4];
      if (nib >= 4'd5) begin
        adj[WIDTH + 4*i +: 4] = nib + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          sreg_d  = {12'd0, bin};
          cap_d   = bin;
          cnt_d   = 4'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = adj << 1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_IT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dig_d   = sreg_q[SW-1 -: 12];
        done_d  = 1'b1;
        last_d  = cap_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      sreg_q  <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      dig_q   <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_hund = dig_q[11:8];
  assign bcd_tens = dig_q[7:4];
  assign bcd_ones = dig_q[3:0];

endmodule

// File: tb/tb_mult_bcd_conv.sv
// Three converters (8-bit manual, 9-bit manual, 8-bit auto) checked against an
// edge-level arithmetic reference model through per-instance scoreboards.
module tb_mult_bcd_conv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bin_a, bin_c;
  logic [8:0] bin_b;
  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [3:0] h_a, t_a, o_a, h_b, t_b, o_b, h_c, t_c, o_c;

  always #5 clk = ~clk;

  mult_bcd_conv #(.WIDTH(8), .AUTO_START(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .bin(bin_a), .start(start), .busy(busy_a), .done(done_a),
    .bcd_hund(h_a), .bcd_tens(t_a), .bcd_ones(o_a));
  mult_bcd_conv #(.WIDTH(9), .AUTO_START(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bin(bin_b), .start(start), .busy(busy_b), .done(done_b),
    .bcd_hund(h_b), .bcd_tens(t_b), .bcd_ones(o_b));
  mult_bcd_conv #(.WIDTH(8), .AUTO_START(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bin(bin_c), .start(start), .busy(busy_c), .done(done_c),
    .bcd_hund(h_c), .bcd_tens(t_c), .bcd_ones(o_c));

  typedef struct {
    int          acc;
    int          due;
    int          val;
    logic [11:0] dig;
  } job_t;

  job_t        q[3][$];
  int          free_e[3];
  int          last_v[3];
  logic [11:0] held[3];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [11:0] bcd_ref(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference: a request is accepted at any edge once the previous job has fully
  // retired; the digits appear WIDTH+1 edges after acceptance.
  task automatic model_step(input int k, input int w, input bit auto_m,
                            input bit r, input bit s, input int v);
    job_t j;
    if (!r) begin
      q[k].delete();
      free_e[k] = cyc + 1;
      last_v[k] = 0;
      held[k]   = 12'd0;
    end else begin
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        held[k]   = q[k][0].dig;
        last_v[k] = q[k][0].val;
      end
      if (cyc >= free_e[k] && (s || (auto_m && v != last_v[k]))) begin
        j.acc = cyc;
        j.due = cyc + w + 1;
        j.val = v;
        j.dig = bcd_ref(v);
        q[k].push_back(j);
        free_e[k] = cyc + w + 2;
      end
    end
  endtask

  task automatic cmp(input string name, input int k, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s[inst %0d] cyc=%0d got=%0h expected=%0h", name, k, cyc, got, exp);
    end
  endtask

  task automatic check(input int k, input int w, input logic d, input logic b,
                       input logic [11:0] dig);
    bit ed = 1'b0;
    bit eb = 1'b0;
    for (int i = 0; i < q[k].size(); i++) begin
      if (q[k][i].acc < cyc && cyc <= q[k][i].acc + w) eb = 1'b1;
    end
    if (q[k].size() > 0 && q[k][0].due == cyc) ed = 1'b1;
    cmp("done", k, int'(d), int'(ed));
    cmp("busy", k, int'(b), int'(eb));
    cmp("digits", k, int'(dig), int'(held[k]));
    if (ed) void'(q[k].pop_front());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0, 8, 1'b0, rst_n, start, int'(bin_a));
      model_step(1, 9, 1'b0, rst_n, start, int'(bin_b));
      model_step(2, 8, 1'b1, rst_n, start, int'(bin_c));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check(0, 8, done_a, busy_a, {h_a, t_a, o_a});
        check(1, 9, done_b, busy_b, {h_b, t_b, o_b});
        check(2, 8, done_c, busy_c, {h_c, t_c, o_c});
      end
    end
  end

  task automatic step(input bit r, input bit s, input int n);
    rst_n = r;
    start = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      free_e[k] = 0;
      last_v[k] = 0;
      held[k]   = 12'd0;
    end
    bin_a = 8'd0;
    bin_b = 9'd0;
    bin_c = 8'd10;
    step(1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 14);
    // 150 / 511 with a single start pulse
    bin_a = 8'd150; bin_b = 9'd511;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 13);
    bin_a = 8'd225; bin_b = 9'd300;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 12);
    bin_a = 8'd0; bin_b = 9'd0;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 12);
    // start re-pulsed and bin changed mid-conversion
    bin_a = 8'd99;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 2);
    bin_a = 8'd7;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 12);
    // reset mid-conversion, then a clean rerun
    bin_a = 8'd144; bin_b = 9'd144;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 12);
    // reset and start in the same cycle
    step(1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 12);
    // auto mode: change while idle, then hold steady
    bin_c = 8'd20;
    step(1'b1, 1'b0, 25);
    bin_c = 8'd255;
    step(1'b1, 1'b0, 3);
    bin_c = 8'd128;
    step(1'b1, 1'b0, 25);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bin_a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) bin_b = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 15) == 0) bin_c = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) == 0), 1);
    end
    step(1'b1, 1'b0, 30);
    for (int k = 0; k < 3; k++) begin
      cmp("drained", k, q[k].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
